// File: rtl/branch_predictor_if.sv
// ID-stage prediction request, MEM-stage resolution and predictor status outputs.
// The master side drives the pipeline inputs; the slave side is the predictor.
interface branch_predictor_if;
  logic [31:0] pc_id;
  logic        branch_early;
  logic        jump_early;
  logic [31:0] imm_id;
  logic        stall;
  logic        flush;
  logic        branch_resolved;
  logic        actual_taken;
  logic        pred_redirect;
  logic [31:0] pred_target;
  logic        jump_taken;
  logic        recover;
  logic [31:0] recover_pc;
  logic [15:0] branch_cnt;
  logic [15:0] mispred_cnt;

  modport master (
    output pc_id, branch_early, jump_early, imm_id, stall, flush, branch_resolved, actual_taken,
    input  pred_redirect, pred_target, jump_taken, recover, recover_pc, branch_cnt, mispred_cnt
  );

  modport slave (
    input  pc_id, branch_early, jump_early, imm_id, stall, flush, branch_resolved, actual_taken,
    output pred_redirect, pred_target, jump_taken, recover, recover_pc, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal predictor: 16 two-bit counters indexed by pc[5:2], with EX/MEM tracking of
// predicted instructions so MEM-stage resolution can train the table and flag recovery.
module branch_predictor (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bus
);
  typedef struct packed {
    logic        valid;
    logic        is_branch;
    logic        pred;
    logic [3:0]  idx;
    logic [31:0] pc;
  } entry_t;

  logic [1:0]  pht_q [16];
  entry_t      ex_q, ex_d, mem_q, mem_d, id_entry;
  logic [3:0]  id_idx;
  logic        pred;
  logic        upd, mispred;
  logic [15:0] branch_cnt_q, mispred_cnt_q;

  assign id_idx = bus.pc_id[5:2];

  always_comb begin
    pred = 1'b0;
    if (!bus.stall && !bus.flush) begin
      pred = bus.jump_early | (bus.branch_early & pht_q[id_idx][1]);
    end
  end

  assign bus.pred_redirect = pred;
  assign bus.pred_target   = bus.pc_id + bus.imm_id;

  // JAL wins if both decode flags are ever set, so it never trains the table.
  always_comb begin
    id_entry.valid     = bus.branch_early | bus.jump_early;
    id_entry.is_branch = bus.branch_early & ~bus.jump_early;
    id_entry.pred      = pred;
    id_entry.idx       = id_idx;
    id_entry.pc        = bus.pc_id;
  end

  always_comb begin
    ex_d  = id_entry;
    mem_d = ex_q;
    if (bus.stall || bus.flush) ex_d = '0;
    if (bus.flush) mem_d = '0;
  end

  assign upd     = bus.branch_resolved & mem_q.valid & mem_q.is_branch;
  assign mispred = upd & (bus.actual_taken != mem_q.pred);

  assign bus.jump_taken  = mem_q.valid & mem_q.pred;
  assign bus.recover     = upd & mem_q.pred & ~bus.actual_taken;
  assign bus.recover_pc  = mem_q.pc + 32'd4;
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pht_q[i] <= 2'b01;
      ex_q          <= '0;
      mem_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      if (upd) begin
        if (bus.actual_taken && pht_q[mem_q.idx] != 2'b11) begin
          pht_q[mem_q.idx] <= pht_q[mem_q.idx] + 2'd1;
        end else if (!bus.actual_taken && pht_q[mem_q.idx] != 2'b00) begin
          pht_q[mem_q.idx] <= pht_q[mem_q.idx] - 2'd1;
        end
        if (branch_cnt_q != 16'hFFFF) branch_cnt_q <= branch_cnt_q + 16'd1;
      end
      if (mispred && mispred_cnt_q != 16'hFFFF) mispred_cnt_q <= mispred_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus queues expected values with a due cycle; a negedge monitor
// pops and compares every entry that falls due.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if bus ();

  branch_predictor dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam int KPr = 0, KPt = 1, KJt = 2, KRec = 3, KRpc = 4, KBc = 5, KMc = 6;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      KPr:     return "pred_redirect";
      KPt:     return "pred_target";
      KJt:     return "jump_taken";
      KRec:    return "recover";
      KRpc:    return "recover_pc";
      KBc:     return "branch_cnt";
      default: return "mispred_cnt";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int k);
    case (k)
      KPr:     return {31'd0, bus.pred_redirect};
      KPt:     return bus.pred_target;
      KJt:     return {31'd0, bus.jump_taken};
      KRec:    return {31'd0, bus.recover};
      KRpc:    return bus.recover_pc;
      KBc:     return {16'd0, bus.branch_cnt};
      default: return {16'd0, bus.mispred_cnt};
    endcase
  endfunction

  // Monitor: compare every expectation that is due in this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [31:0] act;
        act = observe(sb[i].kind);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s cycle %0d: got %h, want %h", kname(sb[i].kind), cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic want(input int kind, input logic [31:0] v, input int dly);
    sb.push_back('{cyc + dly, kind, v});
  endtask

  task automatic idle();
    bus.pc_id = '0; bus.branch_early = 1'b0; bus.jump_early = 1'b0; bus.imm_id = '0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_resolved = 1'b0; bus.actual_taken = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic id(input logic b, input logic j, input logic [31:0] p, input logic [31:0] i);
    bus.branch_early = b; bus.jump_early = j; bus.pc_id = p; bus.imm_id = i;
  endtask

  task automatic res(input logic at);
    bus.branch_resolved = 1'b1; bus.actual_taken = at;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    tick(); tick();
    want(KJt, 0, 0); want(KRec, 0, 0); want(KRpc, 32'h4, 0); want(KBc, 0, 0); want(KMc, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Cold branch at 0x100: weakly not-taken, then trained taken (01->10).
    id(1, 0, 32'h100, 32'h20); want(KPr, 0, 0); want(KPt, 32'h120, 0); want(KJt, 0, 2); tick();
    tick();
    res(1); want(KRec, 0, 0); want(KBc, 1, 1); want(KMc, 1, 1); tick();
    // Second pass predicts taken; taken again (10->11).
    id(1, 0, 32'h100, 32'h20); want(KPr, 1, 0); want(KJt, 1, 2); tick();
    tick();
    res(1); want(KRec, 0, 0); want(KBc, 2, 1); want(KMc, 1, 1); tick();
    // Strongly taken, resolves not-taken: recovery (11->10).
    id(1, 0, 32'h100, 32'h20); want(KPr, 1, 0); want(KPt, 32'h120, 0); want(KJt, 1, 2); tick();
    tick();
    res(0); want(KRec, 1, 0); want(KRpc, 32'h104, 0); want(KBc, 3, 1); want(KMc, 2, 1); tick();
    // Counter 10 still predicts taken; resolve not-taken while ID reads the same index.
    id(1, 0, 32'h100, 32'h20); want(KPr, 1, 0); tick();
    tick();
    res(0); id(1, 0, 32'h100, 32'h20);
    want(KRec, 1, 0); want(KPr, 1, 0); want(KBc, 4, 1); want(KMc, 3, 1); tick();
    id(1, 0, 32'h100, 32'h20); want(KPr, 0, 0); tick();
    want(KJt, 1, 0); tick();
    want(KJt, 0, 0); tick();

    // JAL: always redirects, never trains even if resolution is signalled.
    id(0, 1, 32'h40, 32'hFFFF_FFC0); want(KPr, 1, 0); want(KPt, 32'h0, 0); want(KJt, 1, 2); tick();
    tick();
    res(0); want(KRec, 0, 0); want(KBc, 4, 1); want(KMc, 3, 1); tick();
    id(1, 0, 32'h100, 32'h20); want(KPr, 0, 0); tick();
    tick();
    res(1); want(KBc, 5, 1); want(KMc, 4, 1); tick();

    // Stall then flush; MEM still advances under stall.
    id(1, 0, 32'h100, 32'h20); want(KPr, 1, 0); want(KJt, 1, 2); tick();
    id(1, 0, 32'h100, 32'h20); bus.stall = 1'b1; want(KPr, 0, 0); tick();
    id(1, 0, 32'h100, 32'h20); bus.flush = 1'b1; want(KPr, 0, 0); tick();
    res(1); want(KJt, 0, 0); want(KRec, 0, 0); want(KBc, 5, 1); want(KMc, 4, 1); tick();
    // Flush squashes a valid EX entry.
    id(1, 0, 32'h100, 32'h20); want(KPr, 1, 0); tick();
    bus.flush = 1'b1; tick();
    res(0); want(KJt, 0, 0); want(KRec, 0, 0); want(KBc, 5, 1); want(KMc, 4, 1); tick();

    // Reset mid-flight discards entries and restores weakly not-taken counters.
    id(1, 0, 32'h100, 32'h20); want(KPr, 1, 0); tick();
    rst_n = 1'b0; want(KJt, 0, 0); tick();
    rst_n = 1'b1; want(KJt, 0, 0); want(KBc, 0, 0); want(KMc, 0, 0); tick();
    id(1, 0, 32'h100, 32'h20); want(KPr, 0, 0); tick();

    // Rotate across all 16 indices, always resolving opposite to the prediction:
    // each counter toggles 01<->10, so every branch mispredicts.
    for (int k = 0; k < 65538; k++) begin
      if (k < 65536) id(1, 0, 32'((k % 16) * 4), 32'h0);
      if (k >= 2) res(((k - 2) / 16) % 2 == 0);
      if (k == 16) want(KPr, 1, 0);
      if (k == 32) want(KPr, 0, 0);
      if (k == 19) begin want(KRec, 1, 0); want(KRpc, 32'h8, 0); end
      if (k == 65535) begin want(KBc, 16'hFFFE, 1); want(KMc, 16'hFFFE, 1); end
      if (k >= 65536) begin want(KBc, 16'hFFFF, 1); want(KMc, 16'hFFFF, 1); end
      tick();
    end

    tick(); tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
